legv8_alu_unit: RTL and testbench
=================================

# legv8_alu_unit

Parametrised, handshaked successor to the 32-bit combinational datapath ALU for the LEGv8 execute stage. Adds width parametrisation, an extended operation set (XOR, logical shifts, pass-through, iterative multiply), NZCV condition flags, and valid/ready flow control on both input and output. Single-cycle operations return in one clock. MUL runs as a WIDTH-cycle shift-add sequence. The block sits between the register-read/operand-mux logic and the writeback/flags register.

## Interface
- WIDTH, 32, operand/result width in bits; must be ≥ 4 and a power of 2
- SHW, $clog2(WIDTH), derived; shift-amount width (not overridden)
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operand/op presented
- in_ready  out  1  block can accept this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B / shift amount
- select  in  4  operation code (see Operation)
- out_valid  out  1  result/flags held valid
- out_ready  in  1  consumer takes result this cycle
- result  out  WIDTH  registered result
- flags  out  4  registered {N,Z,C,V}
- op_err  out  1  accepted select was an undefined code

## Operation
- Op codes:
  - 0 AND
  - 1 ORR
  - 2 ADD
  - 3 SUB (a−b)
  - 4 EOR
  - 5 LSL (a << b[SHW-1:0])
  - 6 LSR (logical, a >> b[SHW-1:0])
  - 7 PASS_B
  - 8 MUL (low WIDTH bits of a×b, unsigned)
  - 9–15 undefined
- Shifts ignore b bits above SHW-1.
- Flags:
  - N = result[WIDTH-1]; Z = (result == 0); both for every op.
  - C: ADD carry-out; SUB = 1 when a ≥ b unsigned (ARM no-borrow convention).
  - V: ADD/SUB signed overflow.
  - C = V = 0 for all other ops.
- Undefined code: result 0, flags {0,1,0,0}, op_err = 1, latency as a single-cycle op. op_err = 0 for all defined ops.
- FSM states:
  - IDLE: in_ready = 1, out_valid = 0.
  - BUSY: MUL iterating; in_ready = 0, out_valid = 0.
  - DONE: out_valid = 1; in_ready = out_ready (combinational).
- Transitions:
  - IDLE + in_valid, single-cycle op → DONE.
  - IDLE + in_valid, MUL → BUSY with counter = WIDTH.
  - BUSY → DONE when the counter reaches 0 after the final step.
  - DONE + out_ready, no in_valid → IDLE.
  - DONE + out_ready + in_valid → accept new op: DONE for a single-cycle op, BUSY for MUL.
  - DONE + !out_ready → hold; result/flags/op_err stable.
- MUL datapath: latch multiplicand and multiplier on accept. Each BUSY edge: add multiplicand to the accumulator when the multiplier LSB = 1, then multiplicand <<= 1 and multiplier >>= 1. Accumulator truncated to WIDTH bits.
- Reset:
  - state IDLE; out_valid = 0; in_ready = 1.
  - result = 0; flags = 0; op_err = 0; counter = 0; accumulator = 0.
  - Reset during BUSY or DONE discards the operation with no output.

## Timing
- Single-cycle op accepted at edge k → out_valid = 1 from edge k+1.
- MUL accepted at edge k → out_valid = 1 from edge k+WIDTH.
- in_ready never asserted in BUSY.
- Back-to-back single-cycle ops with out_ready held high give 1 result per cycle.
- Operands and select are sampled only on the accepting edge; later changes have no effect.
- result and flags change only on an edge that enters DONE.

## Structure
- Package legv8_alu_pkg:
  - op-code enum ALU_AND … ALU_MUL
  - flags struct {n,z,c,v}
  - FLAG_* bit-index constants
- Sub-module legv8_seq_mul: iterative shift-add multiplier, parameter WIDTH, start/done pulse interface, owns the counter and accumulator.
- The top level holds the FSM, single-cycle datapath and output registers.

## Test plan
- WIDTH=32, ADD a=0x7FFFFFFF, b=1, out_ready=1 → next cycle result 0x80000000, flags N=1 Z=0 C=0 V=1.
- SUB a=5, b=5 → result 0, flags {0,1,1,0}; then SUB a=3, b=5 → result 0xFFFFFFFE, flags {1,0,0,0}.
- LSL a=1, b=0x21 → result 2 (shift amount 1); LSR a=0x80000000, b=31 → result 1.
- MUL a=0x10001, b=0x10001 → in_ready low for 32 cycles, out_valid at accept+32, result 0x00020001, C=V=0. Assert reset mid-BUSY → out_valid stays 0 and all outputs zero next cycle.
- out_ready held low 5 cycles in DONE with in_valid high → result stable, in_ready = 0; release → new op accepted on the same edge and its result appears the following cycle.
- select=12 → result 0, op_err=1, flags {0,1,0,0}; next defined op clears op_err.

Source files
------------

// File: rtl/legv8_alu_pkg.sv
// legv8_alu_pkg: op codes, flag layout and FSM states shared by the ALU unit
package legv8_alu_pkg;
  typedef enum logic [3:0] {
    ALU_AND    = 4'd0,
    ALU_ORR    = 4'd1,
    ALU_ADD    = 4'd2,
    ALU_SUB    = 4'd3,
    ALU_EOR    = 4'd4,
    ALU_LSL    = 4'd5,
    ALU_LSR    = 4'd6,
    ALU_PASS_B = 4'd7,
    ALU_MUL    = 4'd8
  } alu_op_e;
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} alu_state_e;
endpackage

// File: rtl/legv8_seq_mul.sv
// legv8_seq_mul: WIDTH-step shift-add multiplier, low WIDTH bits of the unsigned product
module legv8_seq_mul
  import legv8_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);
  localparam int CW = $clog2(WIDTH) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
  logic busy;
  always_comb begin
    busy = cnt_q != '0;
    acc_d = start_i ? '0 : busy && mplier_q[0] ? acc_q + mcand_q : acc_q;
    mcand_d = start_i ? a_i : busy ? mcand_q << 1 : mcand_q;
    mplier_d = start_i ? b_i : busy ? mplier_q >> 1 : mplier_q;
    cnt_d = start_i ? CW'(WIDTH) : busy ? cnt_q - CW'(1) : cnt_q;
    done_o = busy && cnt_q == CW'(1);
    product_o = acc_d;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      acc_q <= '0;
      mcand_q <= '0;
      mplier_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
    end
  end
endmodule

// File: rtl/legv8_alu_unit.sv
// legv8_alu_unit: handshaked LEGv8 execute ALU with NZCV flags and iterative MUL
module legv8_alu_unit
  import legv8_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             op_err
);
  alu_state_e state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d, sc_r, mul_prod;
  alu_flags_t flags_q, flags_d;
  logic err_q, err_d, sc_c, sc_v, accept, start_mul, mul_done;
  logic [WIDTH:0] sum, dif;
  legv8_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk(clk),
    .reset(reset),
    .start_i(start_mul),
    .a_i(a),
    .b_i(b),
    .done_o(mul_done),
    .product_o(mul_prod)
  );
  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    dif = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    sc_r = '0;
    sc_c = 1'b0;
    sc_v = 1'b0;
    case (select)
      ALU_AND:    sc_r = a & b;
      ALU_ORR:    sc_r = a | b;
      ALU_ADD: begin
        sc_r = sum[WIDTH-1:0];
        sc_c = sum[WIDTH];
        sc_v = a[WIDTH-1] == b[WIDTH-1] && sum[WIDTH-1] != a[WIDTH-1];
      end
      // carry out of a + ~b + 1 is the ARM no-borrow flag (a >= b unsigned)
      ALU_SUB: begin
        sc_r = dif[WIDTH-1:0];
        sc_c = dif[WIDTH];
        sc_v = a[WIDTH-1] != b[WIDTH-1] && dif[WIDTH-1] != a[WIDTH-1];
      end
      ALU_EOR:    sc_r = a ^ b;
      ALU_LSL:    sc_r = a << b[SHW-1:0];
      ALU_LSR:    sc_r = a >> b[SHW-1:0];
      ALU_PASS_B: sc_r = b;
      default:    sc_r = '0;
    endcase
  end
  always_comb begin
    in_ready = state_q == S_IDLE || (state_q == S_DONE && out_ready);
    out_valid = state_q == S_DONE;
    accept = in_valid && in_ready;
    start_mul = accept && select == ALU_MUL;
    state_d = state_q;
    result_d = result_q;
    flags_d = flags_q;
    err_d = err_q;
    if (start_mul) begin
      state_d = S_BUSY;
    end else if (accept) begin
      state_d = S_DONE;
      result_d = sc_r;
      flags_d[FLAG_N] = sc_r[WIDTH-1];
      flags_d[FLAG_Z] = sc_r == '0;
      flags_d[FLAG_C] = sc_c;
      flags_d[FLAG_V] = sc_v;
      err_d = select > ALU_MUL;
    end else if (state_q == S_BUSY && mul_done) begin
      state_d = S_DONE;
      result_d = mul_prod;
      flags_d = {mul_prod[WIDTH-1], mul_prod == '0, 2'b00};
      err_d = 1'b0;
    end else if (state_q == S_DONE && out_ready) begin
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      result_q <= '0;
      flags_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      result_q <= result_d;
      flags_q <= flags_d;
      err_q <= err_d;
    end
  end
  assign result = result_q;
  assign flags = flags_q;
  assign op_err = err_q;
endmodule

// File: tb/tb_legv8_alu_unit.sv
// tb_legv8_alu_unit: directed vectors with hand-computed results for the ALU unit
module tb_legv8_alu_unit;
  import legv8_alu_pkg::*;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, op_err;
  logic [31:0] a = '0, b = '0, result;
  logic [3:0] select = '0, flags;
  int checks = 0, failures = 0;
  legv8_alu_unit #(.WIDTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .select(select),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .flags(flags),
    .op_err(op_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask
  task automatic single(input string tag, input logic [3:0] s, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] er, input logic [3:0] ef, input logic ee);
    select = s;
    a = x;
    b = y;
    in_valid = 1'b1;
    @(negedge clk);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_res"}, result, er);
    check({tag, "_flags"}, 32'(flags), 32'(ef));
    check({tag, "_err"}, 32'(op_err), 32'(ee));
  endtask
  task automatic mul(input string tag, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] er, input logic [3:0] ef);
    int n = 0, bad = 0;
    select = ALU_MUL;
    a = x;
    b = y;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    select = ALU_ADD;
    a = 32'hDEAD_BEEF;
    b = 32'h1234_5678;
    while (!out_valid && n < 40) begin
      if (in_ready) bad++;
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'd32);
    check({tag, "_busy_rdy"}, 32'(bad), 32'd0);
    check({tag, "_res"}, result, er);
    check({tag, "_flags"}, 32'(flags), 32'(ef));
    check({tag, "_err"}, 32'(op_err), 32'd0);
  endtask
  initial begin
    int bad;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_res", result, 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_err", 32'(op_err), 32'd0);
    reset = 1'b0;
    single("add_ovf", ALU_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 4'b1001, 1'b0);
    single("sub_eq", ALU_SUB, 32'd5, 32'd5, 32'd0, 4'b0110, 1'b0);
    single("sub_lt", ALU_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 4'b1000, 1'b0);
    single("lsl", ALU_LSL, 32'd1, 32'h21, 32'd2, 4'b0000, 1'b0);
    single("lsr", ALU_LSR, 32'h8000_0000, 32'd31, 32'd1, 4'b0000, 1'b0);
    single("and", ALU_AND, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'h00F0_F000, 4'b0000, 1'b0);
    single("orr", ALU_ORR, 32'hF000_0000, 32'd1, 32'hF000_0001, 4'b1000, 1'b0);
    single("eor", ALU_EOR, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 4'b0100, 1'b0);
    single("pass", ALU_PASS_B, 32'h1234_5678, 32'h8000_0000, 32'h8000_0000, 4'b1000, 1'b0);
    single("add_cry", ALU_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'b0110, 1'b0);
    single("undef", 4'd12, 32'h5555_5555, 32'hAAAA_AAAA, 32'd0, 4'b0100, 1'b1);
    single("clr_err", ALU_ADD, 32'd2, 32'd3, 32'd5, 4'b0000, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    check("idle_valid", 32'(out_valid), 32'd0);
    check("idle_ready", 32'(in_ready), 32'd1);
    mul("mul1", 32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 4'b0000);
    mul("mul2", 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 4'b1000);
    mul("mul3", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 4'b0000);
    single("after_mul", ALU_SUB, 32'd9, 32'd2, 32'd7, 4'b0010, 1'b0);
    mul("mul0", 32'd0, 32'h1234, 32'd0, 4'b0100);
    select = ALU_MUL;
    a = 32'h0001_0001;
    b = 32'h0000_0003;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_busy_ready", 32'(in_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("rb_valid", 32'(out_valid), 32'd0);
    check("rb_ready", 32'(in_ready), 32'd1);
    check("rb_res", result, 32'd0);
    check("rb_flags", 32'(flags), 32'd0);
    reset = 1'b0;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    check("rb_no_out", 32'(bad), 32'd0);
    single("stl0", ALU_ADD, 32'd1, 32'd1, 32'd2, 4'b0000, 1'b0);
    out_ready = 1'b0;
    select = ALU_SUB;
    a = 32'd10;
    b = 32'd4;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (result !== 32'd2 || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    check("stall_hold", 32'(bad), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    check("rel_valid", 32'(out_valid), 32'd1);
    check("rel_res", result, 32'd6);
    check("rel_flags", 32'(flags), 32'b0010);
    in_valid = 1'b0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
